// File: rtl/sstv_vis_tx.sv
// SSTV calibration header and VIS code generator: emits a sequence of 12-bit
// tone frequencies (Hz) for leader, break, leader, start bit, 7 data bits, parity, stop.
module sstv_vis_tx #(
  parameter int simulate = 0,
  parameter int CLK_HZ   = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [6:0]  vis_code,
  output logic [11:0] freq,
  output logic        busy,
  output logic        done
);

  // One 10 ms unit; the receive side must derive its counts from the same figure.
  localparam int          UNIT      = (simulate != 0) ? 1000 : CLK_HZ / 100;
  localparam logic [31:0] TICK_LAST = 32'(UNIT - 1);

  localparam logic [11:0] F_LEADER = 12'd1900;
  localparam logic [11:0] F_SYNC   = 12'd1200;
  localparam logic [11:0] F_ONE    = 12'd1100;
  localparam logic [11:0] F_ZERO   = 12'd1300;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEADER1,
    S_BREAK,
    S_LEADER2,
    S_VSTART,
    S_DATA,
    S_PARITY,
    S_VSTOP,
    S_DONE
  } state_t;

  state_t      state, state_next;
  logic [31:0] tick_cnt, tick_next;
  logic [4:0]  unit_cnt, unit_next;
  logic [2:0]  bit_idx, bit_next;
  logic [6:0]  code, code_next;
  logic [11:0] freq_next;
  logic        busy_next, done_next;
  logic        unit_end;
  logic        bit_advance;

  assign unit_end = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      unit_cnt <= '0;
      bit_idx  <= '0;
      code     <= '0;
      freq     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      unit_cnt <= unit_next;
      bit_idx  <= bit_next;
      code     <= code_next;
      freq     <= freq_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    code_next   = code;
    bit_next    = bit_idx;
    tick_next   = tick_cnt;
    unit_next   = unit_cnt;
    freq_next   = 12'd0;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    bit_advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_next = S_LEADER1;
          code_next  = vis_code;
        end
      end
      S_LEADER1: if (unit_end && unit_cnt == 5'd29) state_next = S_BREAK;
      S_BREAK:   if (unit_end && unit_cnt == 5'd0)  state_next = S_LEADER2;
      S_LEADER2: if (unit_end && unit_cnt == 5'd29) state_next = S_VSTART;
      S_VSTART:  if (unit_end && unit_cnt == 5'd2)  state_next = S_DATA;
      S_DATA: begin
        if (unit_end && unit_cnt == 5'd2) begin
          if (bit_idx == 3'd6) begin
            state_next = S_PARITY;
          end else begin
            bit_next    = bit_idx + 3'd1;
            bit_advance = 1'b1;
          end
        end
      end
      S_PARITY:  if (unit_end && unit_cnt == 5'd2) state_next = S_VSTOP;
      S_VSTOP:   if (unit_end && unit_cnt == 5'd2) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase

    if (abort && state != S_IDLE) state_next = S_IDLE;

    // Each data bit restarts the unit count so every bit is timed like its own state.
    if (state_next != state) begin
      tick_next = '0;
      unit_next = '0;
      bit_next  = '0;
    end else if (bit_advance) begin
      tick_next = '0;
      unit_next = '0;
    end else if (state != S_IDLE) begin
      if (unit_end) begin
        tick_next = '0;
        unit_next = unit_cnt + 5'd1;
      end else begin
        tick_next = tick_cnt + 32'd1;
      end
    end

    case (state_next)
      S_LEADER1, S_LEADER2:       freq_next = F_LEADER;
      S_BREAK, S_VSTART, S_VSTOP: freq_next = F_SYNC;
      S_DATA:                     freq_next = code_next[bit_next] ? F_ONE : F_ZERO;
      S_PARITY:                   freq_next = (^code_next) ? F_ONE : F_ZERO;
      default:                    freq_next = 12'd0;
    endcase

    busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
    done_next = (state_next == S_DONE);
  end

endmodule
